h264_mb_pixel_loader: RTL and testbench

H264_MB_PIXEL_LOADER -- requirements
Module: h264_mb_pixel_loader

---
 rtl/h264_mb_pixel_loader.sv | 179 +++++++++++++++++
 tb/tb_h264_mb_pixel_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/h264_mb_pixel_loader.sv
// h264_mb_pixel_loader: double-banked 16-line luma buffer replayed as 4x4-subblock rows per macroblock
module h264_mb_pixel_loader #(
    parameter int MB_WIDTH = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobei,
    input  logic        newline,
    input  logic [31:0] datai,
    output logic        readyi,
    output logic [31:0] pix_o,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [6:0]  mbx_o,
    output logic [3:0]  submb_o,
    output logic [1:0]  row_o,
    output logic        mb_first,
    output logic        mb_last,
    output logic        sync_err,
    output logic        ovf_err
);
    localparam int WPL   = MB_WIDTH * 4;
    localparam int CW    = $clog2(WPL);
    localparam int DEPTH = 32 * WPL;
    localparam int AW    = $clog2(DEPTH);
    typedef enum logic [1:0] {FREE, FILLING, FULL, READING} bank_t;
    bank_t         bst_q [2];
    bank_t         bst_d [2];
    logic          wbank_q, wbank_d, rbank_q, rbank_d;
    logic [3:0]    line_q, line_d;
    logic [CW-1:0] col_q, col_d;
    logic [6:0]    rmbx_q, rmbx_d;
    logic [5:0]    rbeat_q, rbeat_d;
    logic          done_q, done_d;
    logic [31:0]   pix_q, pix_d;
    logic          valid_q, valid_d;
    logic [6:0]    mbx_q, mbx_d;
    logic [5:0]    beat_q, beat_d;
    logic          first_q, first_d, last_q, last_d;
    logic          sync_q, sync_d, ovf_q, ovf_d;
    logic [31:0]   mem_q [DEPTH];
    logic          frame, sync, wrap15, accept, eol, tbank, rel, load, we;
    logic [3:0]    tline, rline;
    logic [CW-1:0] tcol;
    logic [8:0]    rcol;
    logic [AW-1:0] waddr, raddr;
    always_comb begin
        frame  = newline & ~strobei;
        readyi = (bst_q[wbank_q] == FREE) | (bst_q[wbank_q] == FILLING);
        sync   = strobei & newline & (col_q != '0);
        wrap15 = sync & (line_q == 4'd15);
        tbank  = wrap15 ? ~wbank_q : wbank_q;
        tline  = line_q + 4'(sync);
        tcol   = sync ? '0 : col_q;
        accept = strobei & (wrap15 ? (bst_q[~wbank_q] == FREE) : readyi);
        eol    = tcol == CW'(WPL - 1);
        we     = accept & ~reset;
        waddr  = AW'(tbank) * AW'(16 * WPL) + AW'(tline) * AW'(WPL) + AW'(tcol);
        // beat counter is {submb, row}; subblock x/y come from interleaved submb bits
        rline  = {rbeat_q[5], rbeat_q[3], rbeat_q[1:0]};
        rcol   = {rmbx_q, rbeat_q[4], rbeat_q[2]};
        raddr  = AW'(rbank_q) * AW'(16 * WPL) + AW'(rline) * AW'(WPL) + AW'(rcol);
        rel    = valid_q & pix_ready & last_q & (mbx_q == 7'(MB_WIDTH - 1));
        load   = (bst_q[rbank_q] == READING) & ~done_q & (~valid_q | pix_ready);
    end
    always_comb begin
        bst_d   = bst_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        line_d  = line_q;
        col_d   = col_q;
        rmbx_d  = rmbx_q;
        rbeat_d = rbeat_q;
        done_d  = done_q;
        pix_d   = pix_q;
        mbx_d   = mbx_q;
        beat_d  = beat_q;
        first_d = first_q;
        last_d  = last_q;
        sync_d  = sync_q | sync;
        ovf_d   = ovf_q | (strobei & ~accept);
        valid_d = load | (valid_q & ~pix_ready);
        if (bst_q[rbank_q] == FULL) bst_d[rbank_q] = READING;
        if (rel) begin
            bst_d[rbank_q] = FREE;
            rbank_d = ~rbank_q;
            rmbx_d  = '0;
            rbeat_d = '0;
            done_d  = 1'b0;
        end
        if (wrap15) bst_d[wbank_q] = FULL;
        if (wrap15 | accept) begin
            wbank_d = tbank;
            line_d  = tline;
            col_d   = tcol;
        end
        if (accept) begin
            bst_d[tbank] = (eol & (tline == 4'd15)) ? FULL : FILLING;
            wbank_d = (eol & (tline == 4'd15)) ? ~tbank : tbank;
            col_d   = eol ? '0 : tcol + CW'(1);
            line_d  = tline + 4'(eol);
        end
        if (load) begin
            pix_d   = mem_q[raddr];
            mbx_d   = rmbx_q;
            beat_d  = rbeat_q;
            first_d = rbeat_q == 6'd0;
            last_d  = rbeat_q == 6'd63;
            rbeat_d = rbeat_q + 6'd1;
            rmbx_d  = rmbx_q + 7'(rbeat_q == 6'd63);
            done_d  = (rbeat_q == 6'd63) & (rmbx_q == 7'(MB_WIDTH - 1));
        end
        if (frame) begin
            bst_d   = '{FREE, FREE};
            wbank_d = 1'b0;
            rbank_d = 1'b0;
            line_d  = '0;
            col_d   = '0;
            rmbx_d  = '0;
            rbeat_d = '0;
            done_d  = 1'b0;
            pix_d   = '0;
            valid_d = 1'b0;
            mbx_d   = '0;
            beat_d  = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bst_q   <= '{FREE, FREE};
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            line_q  <= '0;
            col_q   <= '0;
            rmbx_q  <= '0;
            rbeat_q <= '0;
            done_q  <= 1'b0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            mbx_q   <= '0;
            beat_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            sync_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bst_q   <= bst_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            line_q  <= line_d;
            col_q   <= col_d;
            rmbx_q  <= rmbx_d;
            rbeat_q <= rbeat_d;
            done_q  <= done_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            mbx_q   <= mbx_d;
            beat_q  <= beat_d;
            first_q <= first_d;
            last_q  <= last_d;
            sync_q  <= sync_d;
            ovf_q   <= ovf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= datai;
    end
    assign pix_o     = pix_q;
    assign pix_valid = valid_q;
    assign mbx_o     = mbx_q;
    assign submb_o   = beat_q[5:2];
    assign row_o     = beat_q[1:0];
    assign mb_first  = first_q;
    assign mb_last   = last_q;
    assign sync_err  = sync_q;
    assign ovf_err   = ovf_q;
endmodule

// File: tb/tb_h264_mb_pixel_loader.sv
// tb_h264_mb_pixel_loader: directed + random stimulus against a frame-image reference model
module tb_h264_mb_pixel_loader;
    localparam int MBW = 2;
    localparam int WPL = MBW * 4;
    typedef struct {
        logic [31:0] data;
        bit          chk;
        int          mbx;
        int          sb;
        int          row;
        bit          first;
        bit          last;
    } beat_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobei = 1'b0;
    logic        newline = 1'b0;
    logic [31:0] datai = '0;
    logic        pix_ready = 1'b0;
    logic        readyi, pix_valid, mb_first, mb_last, sync_err, ovf_err;
    logic [31:0] pix_o;
    logic [6:0]  mbx_o;
    logic [3:0]  submb_o;
    logic [1:0]  row_o;
    h264_mb_pixel_loader #(.MB_WIDTH(MBW)) dut (
        .clk(clk), .reset(reset), .strobei(strobei), .newline(newline), .datai(datai),
        .readyi(readyi), .pix_o(pix_o), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .mbx_o(mbx_o), .submb_o(submb_o), .row_o(row_o), .mb_first(mb_first),
        .mb_last(mb_last), .sync_err(sync_err), .ovf_err(ovf_err)
    );
    always #5 clk = ~clk;
    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    logic [31:0] img[16][WPL];
    bit          wr[16][WPL];
    int          m_line, m_col, banks, beats, rdy_mode, base37;
    bit          d37, prev_stall;
    logic [47:0] prev_out;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic void push_bank();
        for (int mb = 0; mb < MBW; mb++)
            for (int sb = 0; sb < 16; sb++)
                for (int r = 0; r < 4; r++) begin
                    int x4 = ((sb >> 2) & 1) * 2 + (sb & 1);
                    int y4 = ((sb >> 3) & 1) * 2 + ((sb >> 1) & 1);
                    int l = 4 * y4 + r;
                    int c = 4 * mb + x4;
                    exp_q.push_back('{img[l][c], wr[l][c], mb, sb, r, sb == 0 && r == 0, sb == 15 && r == 3});
                end
        for (int l = 0; l < 16; l++)
            for (int c = 0; c < WPL; c++) wr[l][c] = 1'b0;
        banks++;
    endfunction
    function automatic void m_write(input logic [31:0] d, input bit nl);
        if (nl && m_col != 0) begin
            m_line++;
            m_col = 0;
        end
        img[m_line][m_col] = d;
        wr[m_line][m_col] = 1'b1;
        m_col++;
        if (m_col == WPL) begin
            m_col = 0;
            m_line++;
            if (m_line == 16) begin
                push_bank();
                m_line = 0;
            end
        end
    endfunction
    function automatic void m_clear();
        m_line = 0;
        m_col = 0;
        exp_q.delete();
        for (int l = 0; l < 16; l++)
            for (int c = 0; c < WPL; c++) wr[l][c] = 1'b0;
    endfunction
    task automatic cyc();
        pix_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        if (prev_stall)
            chk("stall_hold", {pix_valid, pix_o, mbx_o, submb_o, row_o, mb_first, mb_last}, prev_out);
        if (pix_valid && pix_ready && !reset && !(newline && !strobei)) begin
            int idx = beats - base37;
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else begin
                beat_t e = exp_q.pop_front();
                if (e.chk) chk("beat_data", pix_o, e.data);
                chk("beat_tags", {mbx_o, submb_o, row_o, mb_first, mb_last},
                    {7'(e.mbx), 4'(e.sb), 2'(e.row), e.first, e.last});
            end
            if (d37 && idx == 0) chk("beat0_word0", pix_o, 0);
            if (d37 && idx == 4) chk("beat4_line0_col1", pix_o, 1);
            if (d37 && idx == 8) chk("beat8_line4_col0", pix_o, 32);
            if (d37 && idx == 64) chk("beat64_mbx1_first", {mbx_o, mb_first}, {7'd1, 1'b1});
            beats++;
        end
        prev_stall = pix_valid && !pix_ready && !reset && !(newline && !strobei);
        prev_out = {pix_valid, pix_o, mbx_o, submb_o, row_o, mb_first, mb_last};
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [31:0] d, input bit nl);
        int n = 0;
        strobei = 1'b0;
        newline = 1'b0;
        while (!readyi && n < 3000) begin
            cyc();
            n++;
        end
        if (n == 3000) chk("ready_wait", readyi, 1);
        strobei = 1'b1;
        newline = nl;
        datai = d;
        m_write(d, nl);
        cyc();
        strobei = 1'b0;
        newline = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            cyc();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (3) cyc();
        chk("idle_after_drain", pix_valid, 0);
    endtask
    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, readyi, 1);
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_pix"}, pix_o, 0);
        chk({tag, "_tags"}, {mbx_o, submb_o, row_o, mb_first, mb_last}, 0);
        chk({tag, "_errs"}, {sync_err, ovf_err}, 0);
    endtask
    initial begin
        int n;
        int b0;
        m_clear();
        banks = 0;
        beats = 0;
        rdy_mode = 1;
        prev_stall = 1'b0;
        d37 = 1'b0;
        repeat (2) cyc();
        chk_reset_state("reset");
        reset = 1'b0;
        cyc();
        // linear fill, first-beat latency, directed beat positions
        base37 = beats;
        d37 = 1'b1;
        for (int i = 0; i < 128; i++) send(i, 1'b0);
        chk("lat_edge0", pix_valid, 0);
        cyc();
        chk("lat_edge1", pix_valid, 0);
        cyc();
        chk("lat_edge2", pix_valid, 1);
        drain();
        chk("beats_128", beats - base37, 128);
        d37 = 1'b0;
        // mid-line newline on line 2 col 3
        for (int i = 0; i < 19; i++) send($urandom, i % WPL == 0);
        chk("no_sync_on_col0", sync_err, 0);
        send(32'hC0FFEE03, 1'b1);
        chk("sync_err_set", sync_err, 1);
        b0 = banks;
        while (banks == b0) send($urandom, m_col == 0);
        drain();
        // random backpressure over two banks
        rdy_mode = 2;
        for (int i = 0; i < 256; i++) send($urandom, 1'b0);
        drain();
        // overflow with both banks full
        rdy_mode = 0;
        for (int i = 0; i < 256; i++) send($urandom, 1'b0);
        chk("both_full_ready", readyi, 0);
        chk("ovf_before", ovf_err, 0);
        strobei = 1'b1;
        datai = 32'hDEADBEEF;
        cyc();
        strobei = 1'b0;
        chk("ovf_set", ovf_err, 1);
        chk("ovf_ready", readyi, 0);
        rdy_mode = 1;
        b0 = beats;
        n = 0;
        while (beats - b0 < 64 && n < 1000) begin
            cyc();
            n++;
        end
        chk("ready_after_64", readyi, 0);
        while (beats - b0 < 128 && n < 1000) begin
            cyc();
            n++;
        end
        chk("ready_after_128", readyi, 1);
        drain();
        // frame start with a stalled beat
        rdy_mode = 0;
        for (int i = 0; i < 128; i++) send($urandom, 1'b0);
        n = 0;
        while (!pix_valid && n < 10) begin
            cyc();
            n++;
        end
        chk("valid_before_frame", pix_valid, 1);
        newline = 1'b1;
        cyc();
        newline = 1'b0;
        chk("valid_after_frame", pix_valid, 0);
        chk("ready_after_frame", readyi, 1);
        m_clear();
        rdy_mode = 1;
        for (int i = 0; i < 128; i++) send($urandom, 1'b0);
        n = 0;
        while (!pix_valid && n < 10) begin
            cyc();
            n++;
        end
        chk("first_tags_after_frame", {pix_valid, mbx_o, submb_o, row_o, mb_first}, {1'b1, 7'd0, 4'd0, 2'd0, 1'b1});
        drain();
        // reset mid-line with 37 words stored
        for (int i = 0; i < 37; i++) send($urandom, 1'b0);
        reset = 1'b1;
        cyc();
        chk_reset_state("midreset");
        reset = 1'b0;
        m_clear();
        for (int i = 0; i < 128; i++) send($urandom, 1'b0);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
